// File: rtl/data_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data RAM.
// Each access takes one ACCESS cycle on the RAM and one RESP cycle that pulses the ack.
module data_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ack,

  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ack,

  output logic                ram_ce,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [DATA_W-1:0]   ram_data_o,
  input  logic [DATA_W-1:0]   ram_data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;     // 0 = m0, 1 = m1
  logic   last_grant_q;
  logic   in_access;

  // Next-state and grant selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a
    // path that skips an assignment infers a latch.
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          if (m0_req && m1_req) grant_d = ~last_grant_q;
          else                  grant_d = m1_req;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        // Only the other master can chain; the served master's req is stale here.
        if (grant_q ? m0_req : m1_req) begin
          state_d = ACCESS;
          grant_d = ~grant_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (state_d == ACCESS) last_grant_q <= grant_d;
      if (state_q == ACCESS) begin
        if (grant_q) m1_rdata <= m1_we ? '0 : ram_data_i;
        else         m0_rdata <= m0_we ? '0 : ram_data_i;
      end
    end
  end

  assign in_access = (state_q == ACCESS);

  // RAM command is driven only in ACCESS; ce/we are also killed by reset so an
  // interrupted write never lands in the RAM.
  always_comb begin
    ram_ce     = in_access & ~rst;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_sel    = '0;
    ram_data_o = '0;
    if (in_access) begin
      ram_we     = (grant_q ? m1_we : m0_we) & ~rst;
      ram_addr   = grant_q ? m1_addr  : m0_addr;
      ram_sel    = grant_q ? m1_sel   : m0_sel;
      ram_data_o = grant_q ? m1_wdata : m0_wdata;
    end
  end

  assign m0_ack = (state_q == RESP) & ~grant_q;
  assign m1_ack = (state_q == RESP) &  grant_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed testbench for data_ram_arbiter with a behavioural 64-word RAM model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_data_ram_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              m0_req = 1'b0, m0_we = 1'b0;
  logic [3:0]        m0_sel = 4'h0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;
  logic              m1_req = 1'b0, m1_we = 1'b0;
  logic [3:0]        m1_sel = 4'h0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;
  logic              ram_ce, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_sel;
  logic [DATA_W-1:0] ram_data_o, ram_data_i;

  int tests = 0;
  int fails = 0;

  // RAM model with a backdoor preload port
  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  assign ram_data_i = mem[ram_addr[7:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
    end
  end

  data_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always #5 clk = ~clk;

  // Acks must be mutually exclusive in every cycle
  always @(negedge clk) begin
    tests++;
    if (m0_ack && m1_ack) begin
      fails++;
      $display("FAIL ack_exclusive: m0_ack=%b m1_ack=%b, required not both 1", m0_ack, m1_ack);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin fails++; $display("FAIL reset_acks: got %b%b required 00", m0_ack, m1_ack); end
    tests++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h/%h required 0/0", m0_rdata, m1_rdata); end
    tests++; if (ram_ce !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h0) begin fails++; $display("FAIL reset_ram_cmd: ce=%b we=%b addr=%h required 0 0 0", ram_ce, ram_we, ram_addr); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    preload(6'd4, 32'h12345678);
    m0_we = 1'b0; m0_addr = 32'h10; m0_sel = 4'hF; m0_req = 1'b1;
    step();
    tests++; if (ram_ce !== 1'b1 || ram_we !== 1'b0) begin fails++; $display("FAIL rd_access_ce: ce=%b we=%b required 1 0", ram_ce, ram_we); end
    tests++; if (ram_addr !== 32'h10 || ram_sel !== 4'hF) begin fails++; $display("FAIL rd_access_cmd: addr=%h sel=%h required 10 f", ram_addr, ram_sel); end
    tests++; if (m0_ack !== 1'b0) begin fails++; $display("FAIL rd_early_ack: got %b required 0", m0_ack); end
    step();
    tests++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin fails++; $display("FAIL rd_resp_ack: m0=%b m1=%b required 1 0", m0_ack, m1_ack); end
    tests++; if (ram_ce !== 1'b0 || ram_addr !== 32'h0) begin fails++; $display("FAIL rd_resp_idle_cmd: ce=%b addr=%h required 0 0", ram_ce, ram_addr); end
    tests++; if (m0_rdata !== 32'h12345678) begin fails++; $display("FAIL rd_data: got %h required 12345678", m0_rdata); end
    m0_req = 1'b0;
    step();
    tests++; if (m0_ack !== 1'b0 || ram_ce !== 1'b0) begin fails++; $display("FAIL rd_back_idle: ack=%b ce=%b required 0 0", m0_ack, ram_ce); end
  endtask

  task automatic test_write_read();
    preload(6'd8, 32'h0);
    m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF; m1_sel = 4'hF; m1_req = 1'b1;
    step();
    tests++; if (ram_ce !== 1'b1 || ram_we !== 1'b1) begin fails++; $display("FAIL wr_access_ce: ce=%b we=%b required 1 1", ram_ce, ram_we); end
    tests++; if (ram_addr !== 32'h20 || ram_data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_access_cmd: addr=%h data=%h required 20 deadbeef", ram_addr, ram_data_o); end
    step();
    tests++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin fails++; $display("FAIL wr_ack: m1=%b m0=%b required 1 0", m1_ack, m0_ack); end
    tests++; if (m1_rdata !== 32'h0) begin fails++; $display("FAIL wr_rdata_zero: got %h required 0", m1_rdata); end
    tests++; if (mem[8] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_ram_content: got %h required deadbeef", mem[8]); end
    m1_req = 1'b0;
    step();
    m1_we = 1'b0; m1_req = 1'b1;
    step();
    tests++; if (ram_we !== 1'b0 || ram_addr !== 32'h20) begin fails++; $display("FAIL rd2_access_cmd: we=%b addr=%h required 0 20", ram_we, ram_addr); end
    step();
    tests++; if (m1_ack !== 1'b1) begin fails++; $display("FAIL rd2_ack: got %b required 1", m1_ack); end
    tests++; if (m1_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd2_data: got %h required deadbeef", m1_rdata); end
    tests++; if (m0_rdata !== 32'h12345678) begin fails++; $display("FAIL rd2_m0_hold: got %h required 12345678", m0_rdata); end
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_tie();
    test_reset();
    m0_we = 1'b0; m0_addr = 32'h10; m1_we = 1'b0; m1_addr = 32'h20;
    m0_req = 1'b1; m1_req = 1'b1;
    step();
    tests++; if (ram_ce !== 1'b1 || ram_addr !== 32'h10) begin fails++; $display("FAIL tie_first_m0: ce=%b addr=%h required 1 10", ram_ce, ram_addr); end
    step();
    tests++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin fails++; $display("FAIL tie_m0_ack: m0=%b m1=%b required 1 0", m0_ack, m1_ack); end
    m0_req = 1'b0;
    step();
    tests++; if (ram_ce !== 1'b1 || ram_addr !== 32'h20 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin fails++; $display("FAIL tie_m1_access: ce=%b addr=%h acks=%b%b required 1 20 00", ram_ce, ram_addr, m0_ack, m1_ack); end
    step();
    tests++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin fails++; $display("FAIL tie_m1_ack: m1=%b m0=%b required 1 0", m1_ack, m0_ack); end
    tests++; if (m1_rdata !== 32'hDEADBEEF || m0_rdata !== 32'h12345678) begin fails++; $display("FAIL tie_rdata: m0=%h m1=%h required 12345678 deadbeef", m0_rdata, m1_rdata); end
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n_ack = 0, n0 = 0, n1 = 0;
    m0_we = 1'b0; m0_addr = 32'h10; m1_we = 1'b0; m1_addr = 32'h20;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int cyc = 0; cyc < 40 && n_ack < 10; cyc++) begin
      step();
      if (m0_ack || m1_ack) begin
        tests++;
        if (m0_ack !== (n_ack % 2 == 0)) begin fails++; $display("FAIL fair_order: ack %0d went to m%0d, required m%0d", n_ack, m0_ack ? 0 : 1, n_ack % 2); end
        if (m0_ack) n0++; else n1++;
        n_ack++;
        if (n_ack == 10) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
    end
    tests++; if (n_ack != 10) begin fails++; $display("FAIL fair_timeout: got %0d acks required 10", n_ack); end
    tests++; if (n0 != 5 || n1 != 5) begin fails++; $display("FAIL fair_counts: m0=%0d m1=%0d required 5 5", n0, n1); end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    tests++; if (ram_ce !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin fails++; $display("FAIL fair_drain: ce=%b acks=%b%b required 0 00", ram_ce, m0_ack, m1_ack); end
  endtask

  task automatic test_reset_mid_op();
    preload(6'd12, 32'hA5A5A5A5);
    m0_we = 1'b1; m0_addr = 32'h30; m0_wdata = 32'h11111111; m0_sel = 4'hF; m0_req = 1'b1;
    step();
    tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_we: got %b required 1", ram_we); end
    rst = 1'b1;
    #1;
    tests++; if (ram_ce !== 1'b0 || ram_we !== 1'b0) begin fails++; $display("FAIL rst_mid_gate: ce=%b we=%b required 0 0", ram_ce, ram_we); end
    step();
    tests++; if (mem[12] !== 32'hA5A5A5A5) begin fails++; $display("FAIL rst_mid_ram: got %h required a5a5a5a5", mem[12]); end
    tests++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin fails++; $display("FAIL rst_mid_ack: got %b%b required 00", m0_ack, m1_ack); end
    tests++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin fails++; $display("FAIL rst_mid_rdata: got %h/%h required 0/0", m0_rdata, m1_rdata); end
    m0_req = 1'b0; rst = 1'b0;
    step();
    tests++; if (m0_ack !== 1'b0 || ram_ce !== 1'b0) begin fails++; $display("FAIL rst_mid_after: ack=%b ce=%b required 0 0", m0_ack, ram_ce); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_reset_mid_op();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
